// File: rtl/matmul_host_ctrl.sv
// rtl/matmul_host_ctrl.sv - host-side sequencer: load A/B rows, kick matmul, stream C rows out
module matmul_host_ctrl #(
    parameter int DWIDTH       = 8,
    parameter int MAT_MUL_SIZE = 8,
    parameter int AWIDTH       = 16
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             cmd_start,
    input  logic [AWIDTH-1:0]                base_a,
    input  logic [AWIDTH-1:0]                base_b,
    input  logic [AWIDTH-1:0]                base_c,
    input  logic [AWIDTH-1:0]                stride,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DWIDTH*MAT_MUL_SIZE-1:0]   in_data,
    output logic [AWIDTH-1:0]                bram_addr_a_ext,
    output logic [AWIDTH-1:0]                bram_addr_b_ext,
    output logic [DWIDTH*MAT_MUL_SIZE-1:0]   bram_wdata_a_ext,
    output logic [DWIDTH*MAT_MUL_SIZE-1:0]   bram_wdata_b_ext,
    output logic [DWIDTH*MAT_MUL_SIZE/8-1:0] bram_we_a_ext,
    output logic [DWIDTH*MAT_MUL_SIZE/8-1:0] bram_we_b_ext,
    output logic [AWIDTH-1:0]                bram_addr_c_ext,
    input  logic [DWIDTH*MAT_MUL_SIZE-1:0]   bram_rdata_c_ext,
    output logic [DWIDTH*MAT_MUL_SIZE/8-1:0] bram_we_c_ext,
    output logic [DWIDTH*MAT_MUL_SIZE-1:0]   bram_wdata_c_ext,
    output logic                             start_reg,
    output logic                             clear_done_reg,
    input  logic                             done_mat_mul,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DWIDTH*MAT_MUL_SIZE-1:0]   out_data,
    output logic                             busy,
    output logic                             seq_done
);

    localparam int DATA_W = DWIDTH * MAT_MUL_SIZE;
    localparam int WE_W   = DATA_W / 8;
    localparam int ROW_W  = (MAT_MUL_SIZE > 1) ? $clog2(MAT_MUL_SIZE) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MAT_MUL_SIZE - 1);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LOAD_A  = 4'd1;
    localparam logic [3:0] S_LOAD_B  = 4'd2;
    localparam logic [3:0] S_START   = 4'd3;
    localparam logic [3:0] S_WAIT    = 4'd4;
    localparam logic [3:0] S_RD_ADDR = 4'd5;
    localparam logic [3:0] S_RD_CAP  = 4'd6;
    localparam logic [3:0] S_OUT     = 4'd7;
    localparam logic [3:0] S_CLEAR   = 4'd8;

    logic [3:0]        state;
    logic [ROW_W-1:0]  row;
    logic [AWIDTH-1:0] base_a_q;
    logic [AWIDTH-1:0] base_b_q;
    logic [AWIDTH-1:0] base_c_q;
    logic [AWIDTH-1:0] stride_q;
    logic [AWIDTH-1:0] addr_a_q;
    logic [AWIDTH-1:0] addr_b_q;
    logic [AWIDTH-1:0] addr_c_q;
    logic [DATA_W-1:0] wdata_a_q;
    logic [DATA_W-1:0] wdata_b_q;
    logic [WE_W-1:0]   we_a_q;
    logic [WE_W-1:0]   we_b_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              load_a_hs;
    logic              load_b_hs;
    logic              last_row;

    // Row address: base + row*stride, wrapping naturally at the address width.
    function automatic logic [AWIDTH-1:0] row_addr(input logic [AWIDTH-1:0] base,
                                                   input logic [AWIDTH-1:0] step,
                                                   input logic [ROW_W-1:0]  r);
        return base + step * {{(AWIDTH-ROW_W){1'b0}}, r};
    endfunction

    assign in_ready  = (state == S_LOAD_A) || (state == S_LOAD_B);
    assign load_a_hs = (state == S_LOAD_A) && in_valid;
    assign load_b_hs = (state == S_LOAD_B) && in_valid;
    assign last_row  = (row == LAST_ROW);

    // Sequencer: state, row counter, and the per-sequence address snapshot.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            row      <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            base_c_q <= '0;
            stride_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_start) begin
                        state    <= S_LOAD_A;
                        row      <= '0;
                        base_a_q <= base_a;
                        base_b_q <= base_b;
                        base_c_q <= base_c;
                        stride_q <= stride;
                    end
                end
                S_LOAD_A: begin
                    if (in_valid) begin
                        if (last_row) begin
                            state <= S_LOAD_B;
                            row   <= '0;
                        end else begin
                            row <= row + ROW_W'(1);
                        end
                    end
                end
                S_LOAD_B: begin
                    if (in_valid) begin
                        if (last_row) begin
                            state <= S_START;
                            row   <= '0;
                        end else begin
                            row <= row + ROW_W'(1);
                        end
                    end
                end
                S_START: state <= S_WAIT;
                S_WAIT: begin
                    // A level that is already high simply lets us through at once.
                    if (done_mat_mul) begin
                        state <= S_RD_ADDR;
                        row   <= '0;
                    end
                end
                S_RD_ADDR: state <= S_RD_CAP;
                S_RD_CAP:  state <= S_OUT;
                S_OUT: begin
                    if (out_ready) begin
                        if (last_row) begin
                            state <= S_CLEAR;
                        end else begin
                            state <= S_RD_ADDR;
                            row   <= row + ROW_W'(1);
                        end
                    end
                end
                S_CLEAR: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // A/B write ports: one registered write per accepted input word, enables cleared otherwise.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            wdata_a_q <= '0;
            wdata_b_q <= '0;
            we_a_q    <= '0;
            we_b_q    <= '0;
        end else begin
            we_a_q <= '0;
            we_b_q <= '0;
            if (load_a_hs) begin
                addr_a_q  <= row_addr(base_a_q, stride_q, row);
                wdata_a_q <= in_data;
                we_a_q    <= '1;
            end
            if (load_b_hs) begin
                addr_b_q  <= row_addr(base_b_q, stride_q, row);
                wdata_b_q <= in_data;
                we_b_q    <= '1;
            end
        end
    end

    // C read path: address set on entry to RD_ADDR and held until the row is accepted.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_c_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (done_mat_mul) begin
                        addr_c_q <= base_c_q;
                    end
                end
                S_RD_CAP: begin
                    out_data_q  <= bram_rdata_c_ext;
                    out_valid_q <= 1'b1;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (!last_row) begin
                            addr_c_q <= row_addr(base_c_q, stride_q, row + ROW_W'(1));
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bram_addr_a_ext  = addr_a_q;
    assign bram_addr_b_ext  = addr_b_q;
    assign bram_wdata_a_ext = wdata_a_q;
    assign bram_wdata_b_ext = wdata_b_q;
    assign bram_we_a_ext    = we_a_q;
    assign bram_we_b_ext    = we_b_q;
    assign bram_addr_c_ext  = addr_c_q;
    assign bram_we_c_ext    = '0;
    assign bram_wdata_c_ext = '0;
    assign out_data         = out_data_q;
    assign out_valid        = out_valid_q;
    assign start_reg        = (state == S_START);
    assign clear_done_reg   = (state == S_CLEAR);
    assign seq_done         = (state == S_CLEAR);
    assign busy             = (state != S_IDLE);

endmodule

// File: tb/tb_matmul_host_ctrl.sv
// tb/tb_matmul_host_ctrl.sv - directed self-checking bench for matmul_host_ctrl
module tb_matmul_host_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_start;
    logic [15:0] base_a, base_b, base_c, stride;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [15:0] bram_addr_a_ext, bram_addr_b_ext, bram_addr_c_ext;
    logic [63:0] bram_wdata_a_ext, bram_wdata_b_ext, bram_wdata_c_ext;
    logic [7:0]  bram_we_a_ext, bram_we_b_ext, bram_we_c_ext;
    logic [63:0] bram_rdata_c_ext = 64'd0;
    logic        start_reg, clear_done_reg;
    logic        done_mat_mul = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy, seq_done;

    int checks = 0;
    int failures = 0;
    int done_delay = 20;
    int timer = -1;

    logic [15:0] wa_addr [0:63];
    logic [63:0] wa_data [0:63];
    logic [7:0]  wa_we   [0:63];
    logic [15:0] wb_addr [0:63];
    logic [63:0] wb_data [0:63];
    logic [7:0]  wb_we   [0:63];
    logic [15:0] ro_addr [0:63];
    logic [63:0] ro_data [0:63];
    int na = 0, nb = 0, nr = 0;
    int start_cnt = 0, seq_cnt = 0, clr_cnt = 0;

    always #5 clk = ~clk;

    matmul_host_ctrl #(.DWIDTH(8), .MAT_MUL_SIZE(8), .AWIDTH(16)) dut (
        .clk(clk), .resetn(resetn), .cmd_start(cmd_start),
        .base_a(base_a), .base_b(base_b), .base_c(base_c), .stride(stride),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .bram_addr_a_ext(bram_addr_a_ext), .bram_addr_b_ext(bram_addr_b_ext),
        .bram_wdata_a_ext(bram_wdata_a_ext), .bram_wdata_b_ext(bram_wdata_b_ext),
        .bram_we_a_ext(bram_we_a_ext), .bram_we_b_ext(bram_we_b_ext),
        .bram_addr_c_ext(bram_addr_c_ext), .bram_rdata_c_ext(bram_rdata_c_ext),
        .bram_we_c_ext(bram_we_c_ext), .bram_wdata_c_ext(bram_wdata_c_ext),
        .start_reg(start_reg), .clear_done_reg(clear_done_reg), .done_mat_mul(done_mat_mul),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .seq_done(seq_done)
    );

    function automatic logic [63:0] word(input int i);
        logic [7:0] b;
        b = 8'(i * 17 + 1);
        return 64'h0123_4567_89AB_CDEF ^ {8{b}};
    endfunction

    function automatic logic [63:0] cmem(input logic [15:0] a);
        return {a, ~a, a ^ 16'h5A5A, a + 16'h1234};
    endfunction

    // BRAM C: registered read, one clock of latency
    always @(posedge clk) bram_rdata_c_ext <= cmem(bram_addr_c_ext);

    // matmul engine stand-in: done rises done_delay cycles after start, drops on clear
    always @(negedge clk) begin
        if (!resetn || clear_done_reg) begin
            done_mat_mul <= 1'b0;
            timer        <= -1;
        end else if (start_reg) begin
            if (done_delay == 0) done_mat_mul <= 1'b1;
            else timer <= done_delay;
        end else if (timer > 0) begin
            timer <= timer - 1;
            if (timer == 1) done_mat_mul <= 1'b1;
        end
    end

    // Recorder of writes, accepted output rows and pulses
    always @(negedge clk) begin
        if (bram_we_a_ext != 8'd0 && na < 64) begin
            wa_addr[na] <= bram_addr_a_ext; wa_data[na] <= bram_wdata_a_ext; wa_we[na] <= bram_we_a_ext;
            na <= na + 1;
        end
        if (bram_we_b_ext != 8'd0 && nb < 64) begin
            wb_addr[nb] <= bram_addr_b_ext; wb_data[nb] <= bram_wdata_b_ext; wb_we[nb] <= bram_we_b_ext;
            nb <= nb + 1;
        end
        if (out_valid && out_ready && nr < 64) begin
            ro_addr[nr] <= bram_addr_c_ext; ro_data[nr] <= out_data;
            nr <= nr + 1;
        end
        if (start_reg) start_cnt <= start_cnt + 1;
        if (seq_done) seq_cnt <= seq_cnt + 1;
        if (clear_done_reg) clr_cnt <= clr_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_addrs"}, {bram_addr_a_ext, bram_addr_b_ext, bram_addr_c_ext}, 0);
        chk({tag, "_wdata_a"}, bram_wdata_a_ext, 0);
        chk({tag, "_wdata_b"}, bram_wdata_b_ext, 0);
        chk({tag, "_we"}, {bram_we_a_ext, bram_we_b_ext, bram_we_c_ext}, 0);
        chk({tag, "_wdata_c"}, bram_wdata_c_ext, 0);
        chk({tag, "_pulses"}, {start_reg, clear_done_reg, seq_done}, 0);
    endtask

    task automatic start_cmd(input logic [15:0] ba, input logic [15:0] bb,
                             input logic [15:0] bc, input logic [15:0] st);
        base_a = ba; base_b = bb; base_c = bc; stride = st;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        base_a = ~ba; base_b = ~bb; base_c = ~bc; stride = st + 16'd3;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic load_words(input int stall_after, input bit poke);
        int n;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = word(i);
            n = 0;
            while (!in_ready && n < 50) begin tick(); n++; end
            chk("load_in_ready", in_ready, 1);
            if (poke && i == 10) cmd_start = 1'b1;
            tick();
            cmd_start = 1'b0;
            if (i == stall_after) begin
                in_valid = 1'b0;
                repeat (3) begin
                    tick();
                    chk("stall_no_we", {bram_we_a_ext, bram_we_b_ext}, 0);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic out_phase(input logic [15:0] bc, input logic [15:0] st,
                             input int bp_row, input bit poke);
        int n;
        logic [15:0] ea;
        for (int r = 0; r < 8; r++) begin
            out_ready = (r != bp_row);
            n = 0;
            while (!out_valid && n < 100) begin tick(); n++; end
            chk("out_valid_seen", out_valid, 1);
            ea = bc + 16'(r) * st;
            chk("rd_addr", bram_addr_c_ext, ea);
            chk("out_data", out_data, cmem(ea));
            if (r == bp_row) begin
                repeat (4) begin
                    tick();
                    chk("bp_valid", out_valid, 1);
                    chk("bp_data", out_data, cmem(ea));
                    chk("bp_addr", bram_addr_c_ext, ea);
                end
                out_ready = 1'b1;
            end
            if (poke && r == 4) cmd_start = 1'b1;
            tick();
            cmd_start = 1'b0;
        end
        out_ready = 1'b1;
    endtask

    task automatic run_seq(input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] bc,
                           input logic [15:0] st, input int stall_after, input int bp_row,
                           input bit poke);
        int a0, b0, r0, s0, q0, c0, n;
        logic [15:0] ea;
        a0 = na; b0 = nb; r0 = nr; s0 = start_cnt; q0 = seq_cnt; c0 = clr_cnt;
        start_cmd(ba, bb, bc, st);
        load_words(stall_after, poke);
        out_phase(bc, st, bp_row, poke);
        n = 0;
        while (busy && n < 20) begin tick(); n++; end
        chk("back_to_idle", busy, 0);
        repeat (5) tick();
        chk("busy_stays_idle", busy, 0);
        chk("a_write_count", na - a0, 8);
        chk("b_write_count", nb - b0, 8);
        chk("row_count", nr - r0, 8);
        for (int i = 0; i < 8; i++) begin
            ea = ba + 16'(i) * st;
            chk("a_addr", wa_addr[a0 + i], ea);
            chk("a_data", wa_data[a0 + i], word(i));
            chk("a_we", wa_we[a0 + i], 8'hFF);
            ea = bb + 16'(i) * st;
            chk("b_addr", wb_addr[b0 + i], ea);
            chk("b_data", wb_data[b0 + i], word(8 + i));
            chk("b_we", wb_we[b0 + i], 8'hFF);
            ea = bc + 16'(i) * st;
            chk("row_addr", ro_addr[r0 + i], ea);
            chk("row_data", ro_data[r0 + i], cmem(ea));
        end
        chk("start_pulses", start_cnt - s0, 1);
        chk("seq_done_pulses", seq_cnt - q0, 1);
        chk("clear_pulses", clr_cnt - c0, 1);
    endtask

    initial begin
        int a0, s0, q0, c0;
        resetn = 1'b0; cmd_start = 1'b0; in_valid = 1'b0; in_data = 64'd0; out_ready = 1'b1;
        base_a = 16'd0; base_b = 16'd0; base_c = 16'd0; stride = 16'd0;
        tick(); tick();
        chk_reset_outputs("reset");
        resetn = 1'b1;
        tick();
        chk_reset_outputs("idle");

        // nominal sequence
        run_seq(16'h0000, 16'h0100, 16'h0200, 16'h0008, -1, -1, 1'b0);
        // input stall after word 5, backpressure on row 2, stray cmd_start in LOAD_B and OUT
        run_seq(16'h0040, 16'h1000, 16'h0300, 16'h0010, 5, 2, 1'b1);
        // C address wraps between row 0 and row 1
        run_seq(16'h8000, 16'h9000, 16'hFFF8, 16'h0008, -1, -1, 1'b0);
        chk("wrap_row1_addr", ro_addr[nr - 7], 16'h0000);

        // reset while waiting for the engine
        a0 = na; s0 = start_cnt; q0 = seq_cnt; c0 = clr_cnt;
        start_cmd(16'h0020, 16'h0120, 16'h0220, 16'h0004);
        load_words(-1, 1'b0);
        tick(); tick();
        chk("wait_busy", busy, 1);
        chk("wait_start_pulse", start_cnt - s0, 1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk_reset_outputs("rst_wait");
        repeat (40) tick();
        chk("rst_no_clear", clr_cnt - c0, 0);
        chk("rst_no_seq_done", seq_cnt - q0, 0);
        chk("rst_no_more_writes", na - a0, 8);
        chk("rst_no_more_start", start_cnt - s0, 1);
        chk("rst_idle", busy, 0);

        // restart after reset, engine already done when WAIT is entered
        done_delay = 0;
        run_seq(16'h0010, 16'h0020, 16'h0030, 16'h0048, -1, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
